// File: rtl/mem_rd_credit_buf.sv
// Credit-based read-data buffer between a controller and memory: commands are
// admitted only when enough buffer space is free for their beats.
// Optional overflow detection is enabled with `define MEM_RD_CREDIT_BUF_OVF_CHK_EN.
module mem_rd_credit_buf #(
  parameter int MEM_DATA_W = -1,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_buf_read_en,
  input  logic [6:0]            ctrl_buf_burst_cnt,
  output logic                  buf_ctrl_rdy,
  output logic                  buf_mem_read_en,
  output logic [6:0]            buf_mem_burst_cnt,
  input  logic                  mem_buf_rdy,
  input  logic                  mem_buf_rd_data_val,
  input  logic [MEM_DATA_W-1:0] mem_buf_rd_data,
  output logic                  buf_ctrl_rd_data_val,
  output logic [MEM_DATA_W-1:0] buf_ctrl_rd_data,
  input  logic                  ctrl_buf_rd_data_rdy,
  output logic                  buf_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CW > 7) ? CW : 7;

  if ((DEPTH < 2) || (DEPTH > 128) || ((1 << AW) != DEPTH)) begin : g_depth_chk
    $error("mem_rd_credit_buf: DEPTH must be a power of two in 2..128");
  end

  logic [CW-1:0]         credits;
  logic [CW-1:0]         credits_nxt;
  logic [BW-1:0]         burst_ext;
  logic [BW-1:0]         credits_ext;
  logic                  credit_ok;
  logic                  cmd_hs;
  logic [CW-1:0]         cmd_take;

  logic [MEM_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  rd_val;
  logic                  full;
  logic                  enq;
  logic                  deq;

  // Admission uses only the registered credit count, never this cycle's returns.
  assign burst_ext   = BW'(ctrl_buf_burst_cnt);
  assign credits_ext = BW'(credits);
  assign credit_ok   = (burst_ext <= credits_ext);

  assign buf_mem_read_en   = ctrl_buf_read_en & credit_ok & ~rst;
  assign buf_ctrl_rdy      = mem_buf_rdy & credit_ok & ~rst;
  assign buf_mem_burst_cnt = ctrl_buf_burst_cnt;

  assign cmd_hs   = ctrl_buf_read_en & buf_ctrl_rdy;
  assign cmd_take = cmd_hs ? burst_ext[CW-1:0] : '0;

  assign full = (count == CW'(DEPTH));
  assign deq  = rd_val & ctrl_buf_rd_data_rdy;
  // A beat arriving on a full FIFO is only kept if a slot frees the same cycle.
  assign enq  = mem_buf_rd_data_val & (~full | deq);

  assign buf_ctrl_rd_data_val = rd_val;
  assign buf_ctrl_rd_data     = mem[rd_ptr];

  always_comb begin
    credits_nxt = credits - cmd_take + CW'(deq);
  end

  always_comb begin
    count_nxt = count;
    case ({enq, deq})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CW'(DEPTH);
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_val  <= 1'b0;
    end else begin
      credits <= credits_nxt;
      count   <= count_nxt;
      rd_val  <= (count_nxt != '0);
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by count and rd_val.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= mem_buf_rd_data;
  end

`ifdef MEM_RD_CREDIT_BUF_OVF_CHK_EN
  logic ovf_evt;
  logic ovf_q;

  assign ovf_evt      = mem_buf_rd_data_val & full & ~deq;
  assign buf_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_evt) ovf_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && ovf_evt) $error("mem_rd_credit_buf: read beat dropped, buffer full");
  end
`else
  assign buf_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rd_credit_buf.sv
// Scoreboard bench for mem_rd_credit_buf: a behavioural memory and occupancy
// model predict admission, valid and data; a monitor checks returned beats.
module tb_mem_rd_credit_buf;

  localparam int DEPTH = 16;
  localparam int DW    = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ctrl_buf_read_en = 1'b0;
  logic [6:0]    ctrl_buf_burst_cnt = '0;
  logic          buf_ctrl_rdy;
  logic          buf_mem_read_en;
  logic [6:0]    buf_mem_burst_cnt;
  logic          mem_buf_rdy = 1'b0;
  logic          mem_buf_rd_data_val = 1'b0;
  logic [DW-1:0] mem_buf_rd_data = '0;
  logic          buf_ctrl_rd_data_val;
  logic [DW-1:0] buf_ctrl_rd_data;
  logic          ctrl_buf_rd_data_rdy = 1'b0;
  logic          buf_overflow;

  always #5 clk = ~clk;

  mem_rd_credit_buf #(.MEM_DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ctrl_buf_read_en     (ctrl_buf_read_en),
    .ctrl_buf_burst_cnt   (ctrl_buf_burst_cnt),
    .buf_ctrl_rdy         (buf_ctrl_rdy),
    .buf_mem_read_en      (buf_mem_read_en),
    .buf_mem_burst_cnt    (buf_mem_burst_cnt),
    .mem_buf_rdy          (mem_buf_rdy),
    .mem_buf_rd_data_val  (mem_buf_rd_data_val),
    .mem_buf_rd_data      (mem_buf_rd_data),
    .buf_ctrl_rd_data_val (buf_ctrl_rd_data_val),
    .buf_ctrl_rd_data     (buf_ctrl_rd_data),
    .ctrl_buf_rd_data_rdy (ctrl_buf_rd_data_rdy),
    .buf_overflow         (buf_overflow)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int            occ = 0;       // beats held in the buffer
  int            pend = 0;      // beats requested from memory, not yet returned
  bit            ovf_m = 1'b0;
  bit            seq_mode = 1'b0;
  int            seq_cnt = 0;
  bit            from_pend = 1'b0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && buf_ctrl_rd_data_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_val", 1'b1, 1'b0);
      end else begin
        chk("rd_data", buf_ctrl_rd_data, exp_q[0]);
        if (ctrl_buf_rd_data_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle: drive inputs, check outputs at negedge, advance the model.
  // mmode: 0 memory returns pending beats at random, 1 always, 2 forced extra beat.
  task automatic step(bit r, bit en, int b, bit mrdy, bit crdy, int mmode);
    int credits;
    bit ok, deq, cmd;
    rst                  = r;
    ctrl_buf_read_en     = en;
    ctrl_buf_burst_cnt   = 7'(b);
    mem_buf_rdy          = mrdy;
    ctrl_buf_rd_data_rdy = r ? 1'b0 : crdy;
    mem_buf_rd_data_val  = 1'b0;
    from_pend            = 1'b0;
    if (!r) begin
      if (mmode == 2) begin
        mem_buf_rd_data_val = 1'b1;
      end else if (pend > 0 && (mmode == 1 || $urandom_range(0, 2) != 0)) begin
        mem_buf_rd_data_val = 1'b1;
        from_pend = 1'b1;
      end
    end
    mem_buf_rd_data = seq_mode ? DW'(seq_cnt) : rand_data();
    if (mem_buf_rd_data_val && seq_mode) seq_cnt++;

    @(negedge clk);
    credits = DEPTH - occ - pend;
    ok = (b <= credits);
    chk("ctrl_rdy", buf_ctrl_rdy, !r && mrdy && ok);
    chk("mem_read_en", buf_mem_read_en, !r && en && ok);
    chk("burst_pass", buf_mem_burst_cnt, b[6:0]);
    chk("rd_val", buf_ctrl_rd_data_val, occ > 0);
    chk("overflow", buf_overflow, ovf_m);

    deq = !r && occ > 0 && crdy;
    cmd = !r && en && mrdy && ok;
    if (r) begin
      occ = 0;
      pend = 0;
      ovf_m = 1'b0;
      exp_q.delete();
    end else begin
      if (mem_buf_rd_data_val) begin
        if (from_pend) pend--;
        if (occ == DEPTH && !deq) begin
`ifdef MEM_RD_CREDIT_BUF_OVF_CHK_EN
          ovf_m = 1'b1;
`endif
        end else begin
          exp_q.push_back(mem_buf_rd_data);
          occ++;
        end
      end
      if (deq) occ--;
      if (cmd) pend += b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int max_cyc);
    int n = 0;
    while ((pend > 0 || occ > 0) && n < max_cyc) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b1, 1);
      n++;
    end
    chk("drain_done", (pend + occ) == 0, 1'b1);
  endtask

  task automatic fill_no_consume(int max_cyc);
    int n = 0;
    while (pend > 0 && n < max_cyc) begin
      step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1);
      n++;
    end
    chk("fill_done", occ == DEPTH, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset held: admission gated, outputs cleared.
    step(1'b1, 1'b1, 1, 1'b1, 1'b1, 0);

    // Full-depth burst admitted, follow-up held off; ordered return 0..15.
    seq_mode = 1'b1;
    seq_cnt  = 0;
    step(1'b0, 1'b1, 16, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1, 1'b1, 1'b1, 0);
    drain(100);
    seq_mode = 1'b0;

    // Memory not ready: forwarded but not accepted, credits untouched.
    step(1'b0, 1'b1, 3, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 16, 1'b1, 1'b0, 0);

    // Buffer full, consume and request on the same cycle.
    step(1'b0, 1'b1, 16, 1'b1, 1'b0, 0);
    fill_no_consume(50);
    step(1'b0, 1'b1, 1, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1, 1'b1, 1'b0, 0);
    drain(100);

    // Forced extra beat on a full buffer is dropped, contents intact.
    step(1'b0, 1'b1, 16, 1'b1, 1'b0, 0);
    fill_no_consume(50);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
    drain(100);

    // Reset mid-burst, then a short burst completes.
    step(1'b0, 1'b1, 16, 1'b1, 1'b1, 0);
    repeat (5) step(1'b0, 1'b0, 0, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 16, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 4, 1'b1, 1'b1, 0);
    drain(100);

    // Randomized traffic with occasional resets and oversize bursts.
    for (int i = 0; i < 3000; i++) begin
      bit r, en, mrdy, crdy;
      int b;
      r    = ($urandom_range(0, 399) == 0);
      en   = $urandom_range(0, 1) != 0;
      b    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6);
      mrdy = $urandom_range(0, 3) != 0;
      crdy = $urandom_range(0, 3) != 0;
      step(r, en, b, mrdy, crdy, 0);
    end
    drain(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
